usbh_xfer_sched: RTL and testbench
==================================

# usbh_xfer_sched

Hardware transfer scheduler that sits in front of the USB host's transfer-request interface and sequences endpoint transactions without CPU involvement per packet. Software arms up to 2**SLOT_W endpoint slots. The block picks armed slots round-robin and issues the token and data request. It then classifies the response, retries on NAK in the next frame and on errors up to a limit, tracks the DATA0/DATA1 toggle per slot, and reports per-slot completion.

## Interface
- SLOT_W, 2, slot index width; NUM_SLOTS = 2**SLOT_W
- MAX_ERR, 3, consecutive error retries before a slot is retired with ERR
- clk_i  in  1  clock (48 MHz)
- rst_i  in  1  reset; asynchronous, active-high
- cfg_wr_i  in  1  arm slot cfg_slot_i with the cfg_* fields
- cfg_slot_i  in  SLOT_W  slot index
- cfg_pid_i  in  8  token PID (OUT E1, IN 69, SETUP 2D)
- cfg_dev_i  in  7  device address
- cfg_ep_i  in  4  endpoint number
- cfg_len_i  in  16  OUT/SETUP payload byte count
- cfg_in_i  in  1  IN transfer
- cfg_toggle_i  in  1  initial data toggle
- busy_o  out  NUM_SLOTS  per-slot armed flags
- done_o  out  1  one-cycle completion pulse
- done_slot_o  out  SLOT_W  completed slot
- done_status_o  out  2  00 OK, 01 STALL, 10 ERR, 11 toggle mismatch
- xfer_start_o  out  1  transfer request, held until accepted
- xfer_ack_i  in  1  request accepted by host core
- xfer_token_pid_o  out  8  token PID
- xfer_token_data_o  out  11  {dev[6:0], ep[3:0]}
- xfer_tx_count_o  out  16  payload length
- xfer_data_idx_o  out  1  data toggle (0 = DATA0)
- xfer_in_o  out  1  IN transfer
- rx_done_i  in  1  response/handshake received pulse
- timeout_i  in  1  response timeout pulse
- crc_err_i  in  1  CRC error, valid with rx_done_i
- resp_pid_i  in  8  received PID, valid with rx_done_i
- sof_i  in  1  SOF issued pulse, one per frame

## Operation
- Per-slot registers: valid, nak_wait, toggle, err_cnt (2 bits), pid, dev, ep, len, in.
- Eligible slot: valid and not nak_wait.
- cfg_wr_i to a non-active slot loads all fields, sets valid, and clears nak_wait and err_cnt.
- cfg_wr_i to the slot currently in REQ/WAIT/EVAL is ignored.
- The FSM has four states.
  - IDLE: if any slot is eligible, pick one by round-robin starting at last+1 with wrap. Register cur_slot and the xfer_* fields, set last = cur_slot, go to REQ.
  - REQ: xfer_start_o = 1. On xfer_ack_i, drop xfer_start_o next cycle and go to WAIT.
  - WAIT: on rx_done_i or timeout_i, latch resp_pid_i, crc_err_i and timeout_i, then go to EVAL.
  - EVAL: classify the latched result, update the slot, go to IDLE.
- EVAL outcomes:
  - timeout or crc_err, or an unexpected PID: err_cnt+1. At MAX_ERR, retire the slot with ERR (10); otherwise leave the slot armed for retry.
  - NAK (5A): set nak_wait. err_cnt is unchanged.
  - STALL (1E): retire the slot with STALL (01).
  - OUT/SETUP receives ACK (D2): retire with OK and flip toggle.
  - IN receives DATA0/DATA1 (C3/4B) matching toggle: retire with OK and flip toggle.
  - IN receives DATA0/DATA1 not matching toggle: retire with status 11; toggle unchanged.
- Retire means valid is cleared and done_o pulses. A successful result also clears err_cnt.
- sof_i clears every nak_wait bit.
- If NAK is set and sof_i occurs in the same cycle for the same slot, nak_wait stays set: the set wins.
- The toggle value remains readable for the next arm only via cfg_toggle_i; software maintains its own copy from done_status_o.

## Timing
- Reset values:
  - FSM in IDLE, last = NUM_SLOTS-1 (so slot 0 is served first).
  - All slot registers 0.
  - xfer_start_o, done_o, done_slot_o, done_status_o and busy_o all 0.
  - xfer_* fields 0.
- All outputs are registered.
- From cfg_wr_i (in IDLE, no other slot eligible) to xfer_start_o high: 2 cycles. The write lands in cycle N, IDLE selects in N+1, REQ asserts in N+2.
- xfer_start_o and xfer_* are stable from assertion until the cycle after xfer_ack_i.
- Result pulse to done_o: 2 cycles (WAIT latches, EVAL drives done_o).
- busy_o drops in the same cycle as done_o.
- Back-to-back: after EVAL, the next slot's xfer_start_o rises 2 cycles later.
- A result pulse arriving in REQ is ignored; only WAIT samples rx_done_i and timeout_i.
- rx_done_i and timeout_i together: timeout takes priority (error).
- Reset mid-transfer drops xfer_start_o immediately (asynchronous) and discards all slots.

## Test plan
- Arm slot 0 (IN 69, dev 5, ep 1, toggle 0); rx_done with C3 -> xfer_token_data_o = 0x051, done_o with slot 0 and status 00; busy_o[0] clears.
- Arm slots 0, 1 and 2 together -> requests issued in order 0, 1, 2; after re-arming 0 and 2 while last = 2, slot 0 is served next.
- OUT slot receives NAK (5A) -> no second request before sof_i; retry occurs after sof_i; then ACK -> done status 00, toggle flipped.
- Three consecutive timeout_i with MAX_ERR = 3 -> 3 requests issued, then done status 10; err_cnt resets on re-arm.
- IN with toggle 1 receives C3 -> status 11. STALL 1E on another slot -> status 01.
- Assert rst_i while in WAIT -> xfer_start_o, busy_o and done_o all 0; the first request after reset comes from slot 0.

Source files
------------

// File: rtl/usbh_xfer_sched.sv
// USB host transfer scheduler: round-robin over armed endpoint slots, issues
// token/data requests, classifies handshakes, retries NAK/errors, reports done.

module usbh_xfer_slot (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ld_i,
  input  logic [7:0]  ld_pid_i,
  input  logic [6:0]  ld_dev_i,
  input  logic [3:0]  ld_ep_i,
  input  logic [15:0] ld_len_i,
  input  logic        ld_in_i,
  input  logic        ld_toggle_i,
  input  logic        upd_i,
  input  logic        retire_i,
  input  logic        nak_i,
  input  logic        flip_i,
  input  logic [1:0]  err_cnt_i,
  input  logic        sof_i,
  output logic        valid_o,
  output logic        nak_wait_o,
  output logic        toggle_o,
  output logic [1:0]  err_cnt_o,
  output logic [7:0]  pid_o,
  output logic [6:0]  dev_o,
  output logic [3:0]  ep_o,
  output logic [15:0] len_o,
  output logic        in_o
);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o    <= 1'b0;
      nak_wait_o <= 1'b0;
      toggle_o   <= 1'b0;
      err_cnt_o  <= 2'd0;
      pid_o      <= 8'd0;
      dev_o      <= 7'd0;
      ep_o       <= 4'd0;
      len_o      <= 16'd0;
      in_o       <= 1'b0;
    end else if (ld_i) begin
      valid_o    <= 1'b1;
      nak_wait_o <= 1'b0;
      toggle_o   <= ld_toggle_i;
      err_cnt_o  <= 2'd0;
      pid_o      <= ld_pid_i;
      dev_o      <= ld_dev_i;
      ep_o       <= ld_ep_i;
      len_o      <= ld_len_i;
      in_o       <= ld_in_i;
    end else begin
      if (upd_i) begin
        err_cnt_o <= err_cnt_i;
        if (retire_i) valid_o <= 1'b0;
        if (flip_i) toggle_o <= ~toggle_o;
      end
      // a NAK landing in the same cycle as SOF must still wait a full frame
      if (upd_i && nak_i) nak_wait_o <= 1'b1;
      else if (sof_i)     nak_wait_o <= 1'b0;
    end
  end
endmodule

module usbh_xfer_sched #(
  parameter int SLOT_W  = 2,
  parameter int MAX_ERR = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cfg_wr_i,
  input  logic [SLOT_W-1:0]        cfg_slot_i,
  input  logic [7:0]               cfg_pid_i,
  input  logic [6:0]               cfg_dev_i,
  input  logic [3:0]               cfg_ep_i,
  input  logic [15:0]              cfg_len_i,
  input  logic                     cfg_in_i,
  input  logic                     cfg_toggle_i,
  output logic [(2**SLOT_W)-1:0]   busy_o,
  output logic                     done_o,
  output logic [SLOT_W-1:0]        done_slot_o,
  output logic [1:0]               done_status_o,
  output logic                     xfer_start_o,
  input  logic                     xfer_ack_i,
  output logic [7:0]               xfer_token_pid_o,
  output logic [10:0]              xfer_token_data_o,
  output logic [15:0]              xfer_tx_count_o,
  output logic                     xfer_data_idx_o,
  output logic                     xfer_in_o,
  input  logic                     rx_done_i,
  input  logic                     timeout_i,
  input  logic                     crc_err_i,
  input  logic [7:0]               resp_pid_i,
  input  logic                     sof_i
);
  localparam int NUM_SLOTS = 2**SLOT_W;

  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_EVAL} state_t;
  state_t state_q, state_d;

  logic [NUM_SLOTS-1:0]        valid_a, nak_a, tog_a, in_a;
  logic [NUM_SLOTS-1:0][1:0]   err_a;
  logic [NUM_SLOTS-1:0][7:0]   pid_a;
  logic [NUM_SLOTS-1:0][6:0]   dev_a;
  logic [NUM_SLOTS-1:0][3:0]   ep_a;
  logic [NUM_SLOTS-1:0][15:0]  len_a;

  logic [SLOT_W-1:0] cur_q, last_q, pick, idx;
  logic              pick_vld;
  logic              cfg_blk;
  logic [7:0]        r_pid;
  logic              r_crc, r_to;

  logic       ev_retire, ev_nak, ev_flip;
  logic [1:0] ev_status, ev_err_nxt;
  logic [2:0] ev_err_inc;

  assign busy_o  = valid_a;
  assign cfg_blk = (state_q != S_IDLE) && (cfg_slot_i == cur_q);

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    usbh_xfer_slot u_slot (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .ld_i        (cfg_wr_i && !cfg_blk && (cfg_slot_i == SLOT_W'(g))),
      .ld_pid_i    (cfg_pid_i),
      .ld_dev_i    (cfg_dev_i),
      .ld_ep_i     (cfg_ep_i),
      .ld_len_i    (cfg_len_i),
      .ld_in_i     (cfg_in_i),
      .ld_toggle_i (cfg_toggle_i),
      .upd_i       ((state_q == S_EVAL) && (cur_q == SLOT_W'(g))),
      .retire_i    (ev_retire),
      .nak_i       (ev_nak),
      .flip_i      (ev_flip),
      .err_cnt_i   (ev_err_nxt),
      .sof_i       (sof_i),
      .valid_o     (valid_a[g]),
      .nak_wait_o  (nak_a[g]),
      .toggle_o    (tog_a[g]),
      .err_cnt_o   (err_a[g]),
      .pid_o       (pid_a[g]),
      .dev_o       (dev_a[g]),
      .ep_o        (ep_a[g]),
      .len_o       (len_a[g]),
      .in_o        (in_a[g])
    );
  end

  // round-robin search starting one past the last served slot
  always_comb begin
    pick_vld = 1'b0;
    pick     = last_q;
    idx      = last_q;
    for (int i = 1; i <= NUM_SLOTS; i++) begin
      idx = last_q + SLOT_W'(i);
      if (!pick_vld && valid_a[idx] && !nak_a[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_comb begin
    ev_retire  = 1'b0;
    ev_nak     = 1'b0;
    ev_flip    = 1'b0;
    ev_status  = 2'b00;
    ev_err_nxt = err_a[cur_q];
    ev_err_inc = {1'b0, err_a[cur_q]} + 3'd1;
    if (r_to || r_crc) begin
      ev_err_nxt = ev_err_inc[1:0];
      if (int'(ev_err_inc) >= MAX_ERR) begin
        ev_retire = 1'b1;
        ev_status = 2'b10;
      end
    end else if (r_pid == PID_NAK) begin
      ev_nak = 1'b1;
    end else if (r_pid == PID_STALL) begin
      ev_retire = 1'b1;
      ev_status = 2'b01;
    end else if (!in_a[cur_q] && r_pid == PID_ACK) begin
      ev_retire  = 1'b1;
      ev_flip    = 1'b1;
      ev_err_nxt = 2'd0;
    end else if (in_a[cur_q] && (r_pid == PID_DATA0 || r_pid == PID_DATA1)) begin
      ev_retire = 1'b1;
      if ((r_pid == PID_DATA1) == tog_a[cur_q]) begin
        ev_flip    = 1'b1;
        ev_err_nxt = 2'd0;
      end else begin
        ev_status = 2'b11;
      end
    end else begin
      ev_err_nxt = ev_err_inc[1:0];
      if (int'(ev_err_inc) >= MAX_ERR) begin
        ev_retire = 1'b1;
        ev_status = 2'b10;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (pick_vld) state_d = S_REQ;
      S_REQ:  if (xfer_ack_i) state_d = S_WAIT;
      S_WAIT: if (rx_done_i || timeout_i) state_d = S_EVAL;
      S_EVAL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_q             <= '0;
      last_q            <= '1;
      xfer_start_o      <= 1'b0;
      xfer_token_pid_o  <= 8'd0;
      xfer_token_data_o <= 11'd0;
      xfer_tx_count_o   <= 16'd0;
      xfer_data_idx_o   <= 1'b0;
      xfer_in_o         <= 1'b0;
      done_o            <= 1'b0;
      done_slot_o       <= '0;
      done_status_o     <= 2'b00;
      r_pid             <= 8'd0;
      r_crc             <= 1'b0;
      r_to              <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        S_IDLE: if (pick_vld) begin
          cur_q             <= pick;
          last_q            <= pick;
          xfer_start_o      <= 1'b1;
          xfer_token_pid_o  <= pid_a[pick];
          xfer_token_data_o <= {dev_a[pick], ep_a[pick]};
          xfer_tx_count_o   <= len_a[pick];
          xfer_data_idx_o   <= tog_a[pick];
          xfer_in_o         <= in_a[pick];
        end
        S_REQ: if (xfer_ack_i) xfer_start_o <= 1'b0;
        S_WAIT: if (rx_done_i || timeout_i) begin
          r_pid <= resp_pid_i;
          r_crc <= crc_err_i && rx_done_i;
          r_to  <= timeout_i;
        end
        S_EVAL: if (ev_retire) begin
          done_o        <= 1'b1;
          done_slot_o   <= cur_q;
          done_status_o <= ev_status;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_usbh_xfer_sched.sv
// Directed bench for usbh_xfer_sched: arbitration order, NAK/SOF, error
// retries, toggle check, STALL and reset behaviour.
module tb_usbh_xfer_sched;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_wr_i = 1'b0;
  logic [1:0]  cfg_slot_i = '0;
  logic [7:0]  cfg_pid_i = '0;
  logic [6:0]  cfg_dev_i = '0;
  logic [3:0]  cfg_ep_i = '0;
  logic [15:0] cfg_len_i = '0;
  logic        cfg_in_i = 1'b0;
  logic        cfg_toggle_i = 1'b0;
  logic [3:0]  busy_o;
  logic        done_o;
  logic [1:0]  done_slot_o;
  logic [1:0]  done_status_o;
  logic        xfer_start_o;
  logic        xfer_ack_i = 1'b0;
  logic [7:0]  xfer_token_pid_o;
  logic [10:0] xfer_token_data_o;
  logic [15:0] xfer_tx_count_o;
  logic        xfer_data_idx_o;
  logic        xfer_in_o;
  logic        rx_done_i = 1'b0;
  logic        timeout_i = 1'b0;
  logic        crc_err_i = 1'b0;
  logic [7:0]  resp_pid_i = '0;
  logic        sof_i = 1'b0;

  int n_chk = 0;
  int n_bad = 0;
  int n_req = 0;

  usbh_xfer_sched #(.SLOT_W(2), .MAX_ERR(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_wr_i(cfg_wr_i), .cfg_slot_i(cfg_slot_i), .cfg_pid_i(cfg_pid_i),
    .cfg_dev_i(cfg_dev_i), .cfg_ep_i(cfg_ep_i), .cfg_len_i(cfg_len_i),
    .cfg_in_i(cfg_in_i), .cfg_toggle_i(cfg_toggle_i),
    .busy_o(busy_o), .done_o(done_o), .done_slot_o(done_slot_o),
    .done_status_o(done_status_o),
    .xfer_start_o(xfer_start_o), .xfer_ack_i(xfer_ack_i),
    .xfer_token_pid_o(xfer_token_pid_o), .xfer_token_data_o(xfer_token_data_o),
    .xfer_tx_count_o(xfer_tx_count_o), .xfer_data_idx_o(xfer_data_idx_o),
    .xfer_in_o(xfer_in_o),
    .rx_done_i(rx_done_i), .timeout_i(timeout_i), .crc_err_i(crc_err_i),
    .resp_pid_i(resp_pid_i), .sof_i(sof_i)
  );

  always #10 clk_i = ~clk_i;

  always @(posedge clk_i) if (xfer_start_o && xfer_ack_i) n_req++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic arm(input logic [1:0] s, input logic [7:0] pid, input logic [6:0] dev,
                     input logic [3:0] ep, input logic [15:0] len, input logic in_, input logic tog);
    @(negedge clk_i);
    cfg_wr_i = 1'b1; cfg_slot_i = s; cfg_pid_i = pid; cfg_dev_i = dev;
    cfg_ep_i = ep; cfg_len_i = len; cfg_in_i = in_; cfg_toggle_i = tog;
    @(negedge clk_i);
    cfg_wr_i = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (xfer_start_o) begin ok = 1'b1; break; end
      @(negedge clk_i);
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic do_ack();
    xfer_ack_i = 1'b1;
    @(negedge clk_i);
    xfer_ack_i = 1'b0;
    chk("start_drop", 32'(xfer_start_o), 32'd0);
  endtask

  task automatic resp(input logic [7:0] pid, input logic rx, input logic to, input logic crc);
    rx_done_i = rx; timeout_i = to; crc_err_i = crc; resp_pid_i = pid;
    @(negedge clk_i);
    rx_done_i = 1'b0; timeout_i = 1'b0; crc_err_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [1:0] slot, input logic [1:0] st);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (done_o) begin ok = 1'b1; break; end
    end
    chk({tag, "_seen"}, 32'(ok), 32'd1);
    chk({tag, "_slot"}, 32'(done_slot_o), 32'(slot));
    chk({tag, "_stat"}, 32'(done_status_o), 32'(st));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int base;
    logic [6:0] exp_dev [5];
    logic [1:0] exp_slot [5];
    logic seen;
    exp_dev  = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd1};
    exp_slot = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_start", 32'(xfer_start_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_tok", {13'd0, xfer_token_data_o, xfer_token_pid_o}, 32'd0);

    // single IN on slot 0
    arm(2'd0, 8'h69, 7'd5, 4'd1, 16'd0, 1'b1, 1'b0);
    chk("lat_n1", 32'(xfer_start_o), 32'd0);
    @(negedge clk_i);
    chk("lat_n2", 32'(xfer_start_o), 32'd1);
    chk("t1_tokdata", 32'(xfer_token_data_o), 32'h051);
    chk("t1_pid", 32'(xfer_token_pid_o), 32'h69);
    chk("t1_in", 32'(xfer_in_o), 32'd1);
    chk("t1_idx", 32'(xfer_data_idx_o), 32'd0);
    chk("t1_busy", 32'(busy_o), 32'h1);
    do_ack();
    resp(8'hC3, 1'b1, 1'b0, 1'b0);
    chk("t1_done_early", 32'(done_o), 32'd0);
    @(negedge clk_i);
    chk("t1_done", 32'(done_o), 32'd1);
    chk("t1_slot", 32'(done_slot_o), 32'd0);
    chk("t1_stat", 32'(done_status_o), 32'd0);
    chk("t1_busy_clr", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    chk("t1_pulse", 32'(done_o), 32'd0);

    // round-robin order with re-arms and wrap
    arm(2'd0, 8'hE1, 7'd1, 4'd0, 16'd4, 1'b0, 1'b0);
    arm(2'd1, 8'hE1, 7'd2, 4'd0, 16'd4, 1'b0, 1'b0);
    arm(2'd2, 8'hE1, 7'd3, 4'd0, 16'd4, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      wait_req("rr_req");
      chk("rr_dev", 32'(xfer_token_data_o[10:4]), 32'(exp_dev[k]));
      do_ack();
      if (k == 1) arm(2'd0, 8'hE1, 7'd1, 4'd0, 16'd4, 1'b0, 1'b0);
      if (k == 2) begin
        arm(2'd3, 8'hE1, 7'd4, 4'd0, 16'd4, 1'b0, 1'b0);
        arm(2'd2, 8'hE1, 7'd7, 4'd0, 16'd4, 1'b0, 1'b0);
      end
      resp(8'hD2, 1'b1, 1'b0, 1'b0);
      wait_done("rr_done", exp_slot[k], 2'b00);
      if (k == 2) chk("cfg_active_ignored", 32'(busy_o[2]), 32'd0);
    end
    chk("rr_busy_end", 32'(busy_o), 32'd0);

    // NAK, with SOF coinciding with the NAK update, then a real frame
    base = n_req;
    arm(2'd1, 8'hE1, 7'd7, 4'd2, 16'd8, 1'b0, 1'b0);
    wait_req("nak_req1");
    chk("nak_len", 32'(xfer_tx_count_o), 32'd8);
    chk("nak_pid", 32'(xfer_token_pid_o), 32'hE1);
    do_ack();
    resp(8'h5A, 1'b1, 1'b0, 1'b0);
    sof_i = 1'b1;
    @(negedge clk_i);
    sof_i = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk_i);
      if (xfer_start_o || done_o) seen = 1'b1;
    end
    chk("nak_hold", 32'(seen), 32'd0);
    chk("nak_busy", 32'(busy_o[1]), 32'd1);
    sof_i = 1'b1;
    @(negedge clk_i);
    sof_i = 1'b0;
    wait_req("nak_retry");
    do_ack();
    resp(8'hD2, 1'b1, 1'b0, 1'b0);
    wait_done("nak_done", 2'd1, 2'b00);
    chk("nak_reqs", 32'(n_req - base), 32'd2);

    // error retries: timeout, CRC, rx+timeout together -> ERR
    base = n_req;
    arm(2'd2, 8'h69, 7'd3, 4'd4, 16'd0, 1'b1, 1'b0);
    wait_req("err_req1");
    do_ack();
    resp(8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clk_i);
    chk("err_nodone1", 32'(done_o), 32'd0);
    wait_req("err_req2");
    do_ack();
    resp(8'hC3, 1'b1, 1'b0, 1'b1);
    @(negedge clk_i);
    chk("err_nodone2", 32'(done_o), 32'd0);
    wait_req("err_req3");
    do_ack();
    resp(8'hC3, 1'b1, 1'b1, 1'b0);
    wait_done("err_done", 2'd2, 2'b10);
    chk("err_reqs", 32'(n_req - base), 32'd3);

    // re-arm clears err_cnt: two timeouts then success
    arm(2'd2, 8'h69, 7'd3, 4'd4, 16'd0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      wait_req("rearm_req");
      do_ack();
      resp(8'h00, 1'b0, 1'b1, 1'b0);
      @(negedge clk_i);
      chk("rearm_nodone", 32'(done_o), 32'd0);
    end
    wait_req("rearm_req3");
    do_ack();
    resp(8'hC3, 1'b1, 1'b0, 1'b0);
    wait_done("rearm_done", 2'd2, 2'b00);

    // toggle mismatch, response during REQ ignored
    arm(2'd1, 8'h69, 7'd2, 4'd3, 16'd0, 1'b1, 1'b1);
    wait_req("tog_req");
    chk("tog_idx", 32'(xfer_data_idx_o), 32'd1);
    resp(8'h1E, 1'b1, 1'b0, 1'b0);
    chk("req_ignores_rx", 32'(xfer_start_o), 32'd1);
    do_ack();
    resp(8'hC3, 1'b1, 1'b0, 1'b0);
    wait_done("tog_done", 2'd1, 2'b11);

    // STALL on a SETUP slot
    arm(2'd3, 8'h2D, 7'd2, 4'd0, 16'd8, 1'b0, 1'b0);
    wait_req("stall_req");
    chk("stall_pid", 32'(xfer_token_pid_o), 32'h2D);
    do_ack();
    resp(8'h1E, 1'b1, 1'b0, 1'b0);
    wait_done("stall_done", 2'd3, 2'b01);

    // reset in WAIT and in REQ
    arm(2'd2, 8'hE1, 7'd1, 4'd0, 16'd1, 1'b0, 1'b0);
    wait_req("rst_req1");
    do_ack();
    #3 rst_i = 1'b1;
    #1;
    chk("rstw_start", 32'(xfer_start_o), 32'd0);
    chk("rstw_busy", 32'(busy_o), 32'd0);
    chk("rstw_done", 32'(done_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    arm(2'd3, 8'hE1, 7'd2, 4'd0, 16'd1, 1'b0, 1'b0);
    wait_req("rst_req2");
    #3 rst_i = 1'b1;
    #1;
    chk("rstr_start", 32'(xfer_start_o), 32'd0);
    chk("rstr_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    arm(2'd0, 8'hE1, 7'd9, 4'd0, 16'd1, 1'b0, 1'b0);
    wait_req("post_rst_req");
    chk("post_rst_dev", 32'(xfer_token_data_o[10:4]), 32'd9);
    do_ack();
    resp(8'hD2, 1'b1, 1'b0, 1'b0);
    wait_done("post_rst_done", 2'd0, 2'b00);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
